// File: rtl/fig8_sequencer_pkg.sv
// Shared definitions for the figure-8 motion sequencer: command codes used
// by the byte emitter, the sequencer state encoding and default timing.
package fig8_pkg;

  typedef enum logic [2:0] {
    CMD_STOP     = 3'b000,
    CMD_CW       = 3'b001,
    CMD_CCW      = 3'b010,
    CMD_INIT     = 3'b011,
    CMD_SONGINIT = 3'b100
  } cmd_e;

  typedef enum logic [3:0] {
    ST_BOOT_WAIT,
    ST_SEND_INIT,
    ST_SEND_SONG,
    ST_IDLE,
    ST_SEND_CW,
    ST_RUN_CW,
    ST_SEND_CCW,
    ST_RUN_CCW,
    ST_SEND_STOP
  } seq_state_e;

  // 1 ms tick at 50 MHz; 100 ms wake-up; 500 mm radius half-lap at 200 mm/s.
  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_BOOT_TICKS = 100;
  localparam int DEF_ARC_TICKS  = 15708;
  localparam int DEF_LAPS       = 4;

  // Lap counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fig8_sequencer_if.sv
// Command handshake between the sequencer (master) and the byte emitter
// (slave). A command transfers when cmd_valid and cmd_ready are both high.
interface fig8_sequencer_if;
  logic [2:0] cmd_code;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (output cmd_code, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_code, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/fig8_sequencer_tick_timer.sv
// Prescaled tick timer. Counts clk cycles in ticks of TICK_DIV cycles and
// pulses done_o on the cycle that completes the loaded number of ticks.
// clr_i restarts the count and loads a new terminal tick count.
module tick_timer #(
  parameter int TICK_DIV = 50000,
  parameter int RST_TERM = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic [15:0] term_i,
  output logic        done_o
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [15:0]      tick_q, tick_d, term_q;
  logic [16:0]      tick_inc;
  logic             pre_wrap;

  assign pre_wrap = (pre_q == PRE_LAST);
  assign tick_inc = {1'b0, tick_q} + 17'd1;
  // >= compare: the count parks one short of terminal, so it never wraps.
  assign done_o   = pre_wrap && (tick_inc >= {1'b0, term_q});

  // Next prescaler / tick values while free-running.
  always_comb begin
    pre_d  = pre_q + 1'b1;
    tick_d = tick_q;
    if (pre_wrap) begin
      pre_d = '0;
      if (tick_inc < {1'b0, term_q}) tick_d = tick_inc[15:0];
    end
  end

  // Counter registers with restart/load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= '0;
      term_q <= 16'(RST_TERM);
    end else if (clr_i) begin
      pre_q  <= '0;
      tick_q <= '0;
      term_q <= term_i;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end
endmodule

// File: rtl/fig8_sequencer.sv
// Figure-8 motion scheduler: boots the robot (INIT, SONGINIT), then on go
// alternates CW/CCW arcs for LAPS laps and finishes with STOP. All timing
// lives here; the emitter only serializes the selected command.
module fig8_sequencer
  import fig8_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int BOOT_TICKS = DEF_BOOT_TICKS,
  parameter int ARC_TICKS  = DEF_ARC_TICKS,
  parameter int LAPS       = DEF_LAPS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic                halt,
  fig8_sequencer_if.master    cmd,
  output logic                busy,
  output logic [7:0]          lap_count
);
  localparam logic [7:0] LAPS_V = 8'(LAPS);

  seq_state_e state_q;
  cmd_e       cmd_code_q;
  logic       cmd_valid_q;
  logic       busy_q;
  logic [7:0] lap_count_q;
  logic       halt_pend_q;
  logic       accept;
  logic       tmr_done;
  logic [7:0] lap_inc;

  assign accept    = cmd_valid_q & cmd.cmd_ready;
  assign lap_inc   = sat_inc8(lap_count_q);
  assign cmd.cmd_code  = cmd_code_q;
  assign cmd.cmd_valid = cmd_valid_q;
  assign busy      = busy_q;
  assign lap_count = lap_count_q;

  // Shared timer: boot wait after reset, arc duration after each accept.
  tick_timer #(
    .TICK_DIV (TICK_DIV),
    .RST_TERM (BOOT_TICKS)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .term_i (16'(ARC_TICKS)),
    .done_o (tmr_done)
  );

  // Sequencer FSM with registered command, valid, busy and lap outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT_WAIT;
      cmd_code_q  <= CMD_STOP;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      lap_count_q <= 8'd0;
      halt_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT_WAIT: if (tmr_done) begin
          state_q     <= ST_SEND_INIT;
          cmd_code_q  <= CMD_INIT;
          cmd_valid_q <= 1'b1;
        end
        ST_SEND_INIT: if (accept) begin
          state_q    <= ST_SEND_SONG;
          cmd_code_q <= CMD_SONGINIT;
        end
        ST_SEND_SONG, ST_SEND_STOP: if (accept) begin
          state_q     <= ST_IDLE;
          cmd_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        ST_IDLE: if (go && !halt) begin
          state_q     <= ST_SEND_CW;
          cmd_code_q  <= CMD_CW;
          cmd_valid_q <= 1'b1;
          busy_q      <= 1'b1;
          lap_count_q <= 8'd0;
          halt_pend_q <= 1'b0;
        end
        // A halt seen while an arc command is pending is remembered and
        // acted on once that command has been taken.
        ST_SEND_CW, ST_SEND_CCW: begin
          if (accept) begin
            halt_pend_q <= 1'b0;
            if (halt_pend_q || halt) begin
              state_q    <= ST_SEND_STOP;
              cmd_code_q <= CMD_STOP;
            end else begin
              state_q     <= (state_q == ST_SEND_CW) ? ST_RUN_CW : ST_RUN_CCW;
              cmd_valid_q <= 1'b0;
            end
          end else if (halt) begin
            halt_pend_q <= 1'b1;
          end
        end
        ST_RUN_CW: begin
          if (halt) begin
            state_q     <= ST_SEND_STOP;
            cmd_code_q  <= CMD_STOP;
            cmd_valid_q <= 1'b1;
          end else if (tmr_done) begin
            state_q     <= ST_SEND_CCW;
            cmd_code_q  <= CMD_CCW;
            cmd_valid_q <= 1'b1;
          end
        end
        ST_RUN_CCW: begin
          if (halt) begin
            state_q     <= ST_SEND_STOP;
            cmd_code_q  <= CMD_STOP;
            cmd_valid_q <= 1'b1;
          end else if (tmr_done) begin
            lap_count_q <= lap_inc;
            cmd_valid_q <= 1'b1;
            if (LAPS_V != 8'd0 && lap_inc >= LAPS_V) begin
              state_q    <= ST_SEND_STOP;
              cmd_code_q <= CMD_STOP;
            end else begin
              state_q    <= ST_SEND_CW;
              cmd_code_q <= CMD_CW;
            end
          end
        end
        default: begin
          state_q     <= ST_BOOT_WAIT;
          cmd_valid_q <= 1'b0;
          busy_q      <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/fig8_sequencer.md
Name: fig8_sequencer

Overview:
Top-level motion scheduler for the figure-8 robot. After power-up it issues INIT and SONGINIT, then on `go` alternates clockwise and counter-clockwise arcs of fixed duration for a set number of laps, ending with STOP. It drives the command-code/valid inputs of the byte-emitter block (the UART command serializer) through a valid/ready handshake. It owns all timing; the emitter only serializes the selected command.

Parameters:
TICK_DIV, 50000, clk cycles per timing tick (1 ms at 50 MHz); range 2..2^20.
BOOT_TICKS, 100, ticks to wait after reset before INIT is sent (robot wake-up).
ARC_TICKS, 15708, ticks per arc (half-lap). 500 mm radius at 200 mm/s gives 15708 ms. 16-bit max.
LAPS, 4, figure-8 laps per run; 0 = run until halt. 8-bit.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
go  in  1  single-cycle start request; honoured only in IDLE
halt  in  1  level stop request
cmd_code  out  3  command select to emitter (see package codes)
cmd_valid  out  1  command request; held until accepted
cmd_ready  in  1  emitter idle; accept = cmd_valid & cmd_ready in the same cycle
busy  out  1  high in every state except IDLE
lap_count  out  8  completed laps in current or last run; saturates at 255

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - state BOOT_WAIT, cmd_code=CMD_STOP, cmd_valid=0, busy=1, lap_count=0.
  - tick prescaler and tick counter to 0.
  - Reset mid-handshake drops cmd_valid on the next edge; no accept is counted.
- States and transitions:
  - BOOT_WAIT: exactly BOOT_TICKS*TICK_DIV cycles after the first cycle with rst_n high, go to SEND_INIT.
  - SEND_INIT (code INIT): on accept, go to SEND_SONG.
  - SEND_SONG (code SONGINIT): on accept, go to IDLE.
  - IDLE: busy=0, cmd_valid=0. `go` & !halt: clear lap_count, go to SEND_CW.
  - SEND_CW (code CW): on accept, go to RUN_CW.
  - RUN_CW: after ARC_TICKS*TICK_DIV cycles, go to SEND_CCW.
  - SEND_CCW (code CCW): on accept, go to RUN_CCW.
  - RUN_CCW: after ARC_TICKS*TICK_DIV cycles, lap_count+1 (saturating). Then, if LAPS!=0 and new count ≥ LAPS, go to SEND_STOP; else go to SEND_CW.
  - SEND_STOP (code STOP): on accept, go to IDLE.
- Timing:
  - Timer and prescaler clear on every accept cycle and on entry to BOOT_WAIT.
  - RUN duration is measured from the accept cycle; cmd_valid for the next command rises exactly ARC_TICKS*TICK_DIV cycles after the accept edge.
- Handshake:
  - cmd_code is stable while cmd_valid=1.
  - cmd_valid deasserts the cycle after accept unless the next state is also a SEND state. In that case the new code appears with cmd_valid still 1 (back-to-back allowed).
  - The emitter may hold cmd_ready low indefinitely; the FSM waits, with no timeout.
- halt:
  - In RUN_CW/RUN_CCW: go to SEND_STOP next cycle; the timer is abandoned; lap_count is not incremented.
  - In SEND_CW/SEND_CCW: complete the pending handshake (code unchanged), then go to SEND_STOP.
  - In BOOT_WAIT, SEND_INIT, SEND_SONG, SEND_STOP, IDLE: no effect.
  - go and halt together in IDLE: halt wins, stay IDLE.
- go outside IDLE is ignored, not queued.
- Widths:
  - Prescaler is ceil(log2(TICK_DIV)) bits; tick counter is 16 bits.
  - Compare uses ≥ terminal value so no wrap occurs.

Decomposition:
- Package fig8_pkg holds:
  - command codes CMD_STOP=3'b000, CMD_CW=3'b001, CMD_CCW=3'b010, CMD_INIT=3'b011, CMD_SONGINIT=3'b100 (shared with the byte emitter, whose select widens to 3 bits);
  - sequencer state enum;
  - default timing constants.
- One sub-module, tick_timer: prescaler plus tick counter with clear, load of terminal count, and a done pulse. It is instantiated once and reused by BOOT_WAIT and RUN states.

Test Plan:
All scenarios use TICK_DIV=4, BOOT_TICKS=2, ARC_TICKS=3, LAPS=2.
1. Release reset, cmd_ready=1 -> cmd_valid rises 8 cycles after release with code 3; the next cycle shows code 4; then IDLE with busy=0.
2. Pulse go in IDLE, cmd_ready=1 -> code sequence 1,2,1,2,0. Each next valid is 12 cycles after the prior accept; lap_count goes 1 then 2; ends in IDLE.
3. Hold cmd_ready=0 for 20 cycles during SEND_CW -> cmd_valid=1 and code=1 stable throughout; accept on the cycle cmd_ready rises; RUN timing starts there.
4. Assert halt 5 cycles into RUN_CCW on lap 1 -> code 0 valid on the next cycle; lap_count stays 0; IDLE after accept.
5. go and halt together in IDLE -> remains IDLE, cmd_valid=0. go during RUN_CW -> ignored, sequence unchanged.
6. Pull rst_n low while cmd_valid=1 in SEND_CCW -> next edge shows cmd_valid=0, code=0, lap_count=0, busy=1; boot sequence repeats.
